// File: rtl/mul_err_pkg.sv
// ============================================================================
// Module : mul_err_pkg
// Brief  : Shared widths, sweep defaults and state encoding for the
//          multiplier error monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mul_err_pkg;

    localparam int W          = 8;
    localparam int PW         = 2 * W;
    localparam int OP_MIN_DEF = 1;
    localparam int OP_MAX_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/err_dist.sv
// ============================================================================
// Module : err_dist
// Brief  : Combinational absolute distance |x - y| and inequality flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module err_dist
    import mul_err_pkg::*;
#(
    parameter int DW = PW
) (
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_y,
    output logic [DW-1:0] o_dist,
    output logic          o_neq
);

    // One extra bit keeps the full unsigned range representable as a signed difference.
    logic signed [DW:0] w_diff;

    assign w_diff = $signed({1'b0, i_x}) - $signed({1'b0, i_y});
    assign o_dist = w_diff[DW] ? DW'(-w_diff) : w_diff[DW-1:0];
    assign o_neq  = (i_x != i_y);

endmodule

`default_nettype wire

// File: rtl/mul_err_monitor.sv
// ============================================================================
// Module : mul_err_monitor
// Brief  : Sweeps operand pairs into an external multiplier and accumulates
//          error-distance statistics against an exact product.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mul_err_monitor
    import mul_err_pkg::*;
#(
    parameter int W      = mul_err_pkg::W,
    parameter int OP_MIN = OP_MIN_DEF,
    parameter int OP_MAX = OP_MAX_DEF,
    parameter int CNT_W  = 17,
    parameter int SUM_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [W-1:0]       op_a,
    output logic [W-1:0]       op_b,
    input  logic [2*W-1:0]     prod_in,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   err_sum,
    output logic [2*W-1:0]     err_max,
    output logic [CNT_W-1:0]   num_wrong,
    output logic [CNT_W-1:0]   num_total
);

    localparam int             c_pw     = 2 * W;
    localparam logic [W-1:0]   c_op_min = W'(OP_MIN);
    localparam logic [W-1:0]   c_op_max = W'(OP_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start_sweep;
    logic               w_last_pair;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [c_pw-1:0]    w_exact;
    logic [c_pw-1:0]    r_prod_q;
    logic [c_pw-1:0]    r_exact_q;
    logic               r_valid_q;
    logic [c_pw-1:0]    w_dist;
    logic               w_neq;
    logic               r_done;
    logic [SUM_W-1:0]   r_err_sum;
    logic [c_pw-1:0]    r_err_max;
    logic [CNT_W-1:0]   r_num_wrong;
    logic [CNT_W-1:0]   r_num_total;

    assign w_last_pair = (r_op_a == c_op_max) && (r_op_b == c_op_max);
    assign w_exact     = c_pw'(r_op_a) * c_pw'(r_op_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start)       w_state_nxt = SWEEP;
            SWEEP:      if (w_last_pair) w_state_nxt = DRAIN;
            DRAIN:                       w_state_nxt = DONE;
            default:                     w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state == SWEEP) || (r_state == DRAIN);
        w_start_sweep = ((r_state == IDLE) || (r_state == DONE)) && start;
        done          = r_done;
    end

    // op_b is the inner loop; operands freeze on the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= c_op_min;
            r_op_b <= c_op_min;
        end else if (w_start_sweep) begin
            r_op_a <= c_op_min;
            r_op_b <= c_op_min;
        end else if ((r_state == SWEEP) && !w_last_pair) begin
            if (r_op_b == c_op_max) begin
                r_op_b <= c_op_min;
                r_op_a <= r_op_a + W'(1);
            end else begin
                r_op_b <= r_op_b + W'(1);
            end
        end
    end

    assign op_a = r_op_a;
    assign op_b = r_op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_prod_q  <= '0;
            r_exact_q <= '0;
            r_done    <= 1'b0;
        end else begin
            r_valid_q <= (r_state == SWEEP);
            r_prod_q  <= prod_in;
            r_exact_q <= w_exact;
            r_done    <= (r_state == DRAIN);
        end
    end

    err_dist #(
        .DW     (c_pw)
    ) u_err_dist (
        .i_x    (r_prod_q),
        .i_y    (r_exact_q),
        .o_dist (w_dist),
        .o_neq  (w_neq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sum   <= '0;
            r_err_max   <= '0;
            r_num_wrong <= '0;
            r_num_total <= '0;
        end else if (w_start_sweep) begin
            r_err_sum   <= '0;
            r_err_max   <= '0;
            r_num_wrong <= '0;
            r_num_total <= '0;
        end else if (r_valid_q) begin
            r_err_sum   <= r_err_sum + SUM_W'(w_dist);
            if (w_dist > r_err_max) begin
                r_err_max <= w_dist;
            end
            r_num_wrong <= r_num_wrong + CNT_W'(w_neq);
            r_num_total <= r_num_total + CNT_W'(1);
        end
    end

    assign err_sum   = r_err_sum;
    assign err_max   = r_err_max;
    assign num_wrong = r_num_wrong;
    assign num_total = r_num_total;

endmodule

`default_nettype wire

// File: tb/tb_mul_err_monitor.sv
// ============================================================================
// Module : tb_mul_err_monitor
// Brief  : Scoreboard bench for mul_err_monitor with a behavioural multiplier
//          response and a sweep-level statistics model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_err_monitor;

    localparam int LO_A = 230;
    localparam int HI_A = 255;
    localparam int NA   = (HI_A - LO_A + 1) * (HI_A - LO_A + 1);
    localparam int LO_B = 250;
    localparam int HI_B = 252;
    localparam int NB   = (HI_B - LO_B + 1) * (HI_B - LO_B + 1);

    typedef struct {
        longint sum;
        longint mx;
        longint wrong;
        longint total;
        longint done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [7:0]  op_a_a, op_b_a, op_a_b, op_b_b;
    logic [15:0] prod_a, prod_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] err_sum_a, err_sum_b;
    logic [15:0] err_max_a, err_max_b;
    logic [16:0] num_wrong_a, num_total_a, num_wrong_b, num_total_b;

    int     mode_a = 0, seed_a = 0, mode_b = 0, seed_b = 0;
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    exp_t   qa[$];
    exp_t   qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier behaviour: 0 exact, 1 exact+1 at (mx,mx), 2 zero, else sparse XOR errors.
    function automatic logic [15:0] resp(int mode, int a, int b, int seed, int mx);
        int e;
        e = a * b;
        case (mode)
            0:       return 16'(e);
            1:       return (a == mx && b == mx) ? 16'(e + 1) : 16'(e);
            2:       return 16'd0;
            default: return (((a * 7 + b * 13 + seed) % 5) == 0) ?
                            (16'(e) ^ 16'((seed % 65535) + 1)) : 16'(e);
        endcase
    endfunction

    function automatic exp_t model(int mode, int seed, int lo, int hi);
        exp_t r;
        longint p, e, d;
        r.sum = 0; r.mx = 0; r.wrong = 0; r.total = 0; r.done_cyc = 0;
        for (int a = lo; a <= hi; a++) begin
            for (int b = lo; b <= hi; b++) begin
                p = longint'(resp(mode, a, b, seed, hi));
                e = a * b;
                d = (p > e) ? p - e : e - p;
                r.sum += d;
                if (d > r.mx) r.mx = d;
                if (d != 0) r.wrong++;
                r.total++;
            end
        end
        return r;
    endfunction

    assign prod_a = resp(mode_a, int'(op_a_a), int'(op_b_a), seed_a, HI_A);
    assign prod_b = resp(mode_b, int'(op_a_b), int'(op_b_b), seed_b, HI_B);

    mul_err_monitor #(.OP_MIN(LO_A), .OP_MAX(HI_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .op_a(op_a_a), .op_b(op_b_a), .prod_in(prod_a),
        .busy(busy_a), .done(done_a),
        .err_sum(err_sum_a), .err_max(err_max_a),
        .num_wrong(num_wrong_a), .num_total(num_total_a)
    );

    mul_err_monitor #(.OP_MIN(LO_B), .OP_MAX(HI_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .op_a(op_a_b), .op_b(op_b_b), .prod_in(prod_b),
        .busy(busy_b), .done(done_b),
        .err_sum(err_sum_b), .err_max(err_max_b),
        .num_wrong(num_wrong_b), .num_total(num_total_b)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t ex;
        if (rst_n && done_a) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                ex = qa.pop_front();
                chk("a_err_sum",   64'(err_sum_a),   ex.sum);
                chk("a_err_max",   64'(err_max_a),   ex.mx);
                chk("a_num_wrong", 64'(num_wrong_a), ex.wrong);
                chk("a_num_total", 64'(num_total_a), ex.total);
                chk("a_done_cycle", cyc, ex.done_cyc);
                chk("a_busy_in_done", 64'(busy_a), 64'd0);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t ex;
        if (rst_n && done_b) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                ex = qb.pop_front();
                chk("b_err_sum",   64'(err_sum_b),   ex.sum);
                chk("b_err_max",   64'(err_max_b),   ex.mx);
                chk("b_num_wrong", 64'(num_wrong_b), ex.wrong);
                chk("b_num_total", 64'(num_total_b), ex.total);
                chk("b_done_cycle", cyc, ex.done_cyc);
            end
        end
    end

    task automatic wait_empty_a(int budget);
        int n = 0;
        while (qa.size() != 0 && n < budget) begin
            @(negedge clk); #2; n++;
        end
        if (qa.size() != 0) begin
            chk("a_done_timeout", 64'd0, 64'd1);
            qa.delete();
        end
    endtask

    task automatic wait_empty_b(int budget);
        int n = 0;
        while (qb.size() != 0 && n < budget) begin
            @(negedge clk); #2; n++;
        end
        if (qb.size() != 0) begin
            chk("b_done_timeout", 64'd0, 64'd1);
            qb.delete();
        end
    endtask

    task automatic run_a(int mode, int seed, bit hold);
        exp_t ex;
        @(negedge clk);
        mode_a = mode; seed_a = seed; start_a = 1'b1;
        @(posedge clk); #1;
        ex = model(mode, seed, LO_A, HI_A);
        ex.done_cyc = cyc + NA + 1;
        qa.push_back(ex);
        chk("a_busy_after_start", 64'(busy_a), 64'd1);
        if (!hold) start_a = 1'b0;
        wait_empty_a(NA + 20);
        if (hold) begin
            @(posedge clk); #1;
            ex.done_cyc = cyc + NA + 1;
            qa.push_back(ex);
            chk("a_restart_after_done", 64'(busy_a), 64'd1);
            start_a = 1'b0;
            wait_empty_a(NA + 20);
        end
    endtask

    task automatic run_b(int mode, int seed);
        exp_t ex;
        @(negedge clk);
        mode_b = mode; seed_b = seed; start_b = 1'b1;
        @(posedge clk); #1;
        ex = model(mode, seed, LO_B, HI_B);
        ex.done_cyc = cyc + NB + 1;
        qb.push_back(ex);
        start_b = 1'b0;
        wait_empty_b(NB + 20);
    endtask

    task automatic chk_a_reset(string tag);
        chk({tag, "_busy"},      64'(busy_a),      64'd0);
        chk({tag, "_done"},      64'(done_a),      64'd0);
        chk({tag, "_op_a"},      64'(op_a_a),      64'(LO_A));
        chk({tag, "_op_b"},      64'(op_b_a),      64'(LO_A));
        chk({tag, "_err_sum"},   64'(err_sum_a),   64'd0);
        chk({tag, "_err_max"},   64'(err_max_a),   64'd0);
        chk({tag, "_num_wrong"}, 64'(num_wrong_a), 64'd0);
        chk({tag, "_num_total"}, 64'(num_total_a), 64'd0);
    endtask

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1);
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_a_reset("rst");
        chk("rst_b_busy", 64'(busy_b), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_a(0, 0, 1'b0);
        run_a(1, 0, 1'b0);
        run_a(2, 0, 1'b0);
        for (int i = 0; i < 4; i++) run_a(3, int'($urandom_range(0, 1000000)), 1'b0);

        run_b(0, 0);
        run_b(3, int'($urandom_range(0, 1000000)));

        run_a(3, int'($urandom_range(0, 1000000)), 1'b1);

        // Abort mid-sweep with reset and confirm no resumption or done pulse.
        @(negedge clk);
        mode_a = 2; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n = 0;
        while (!(op_a_a == 8'd240 && op_b_a == 8'd237) && n < NA + 5) begin
            @(negedge clk); n++;
        end
        chk("abort_pair_reached", 64'(op_a_a == 8'd240 && op_b_a == 8'd237), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_a_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk_a_reset("post_abort");

        run_a(0, 0, 1'b0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
